// File: rtl/riscv_pkg.sv
// Shared register-file definitions for the integer pipeline.
package riscv_pkg;

    localparam int REG_NUM_BITWIDTH = 5;
    localparam int NREG             = 2 ** REG_NUM_BITWIDTH;

    typedef logic [REG_NUM_BITWIDTH-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = {REG_NUM_BITWIDTH{1'b0}};

    // x0 is hard-wired zero: it never carries a real dependency.
    function automatic logic is_live_reg(input reg_idx_t idx);
        return (idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_detection_unit_chk.sv
// Protocol checks for the long-op counter.
module hazard_detection_unit_chk #(
    parameter int MAX_LONG = 4
) (
    input logic       clk,
    input logic       rst_n,
    input logic       inc,
    input logic       dec,
    input logic [3:0] long_count
);

    // A writeback with nothing outstanding means the producer lost track.
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(dec && !inc && (long_count == 4'd0)));

    // Issue is throttled, so the counter can never pass the limit.
    a_within_limit: assert property (@(posedge clk) disable iff (!rst_n)
        (long_count <= 4'(MAX_LONG)));

endmodule

// File: rtl/hazard_scoreboard.sv
// Busy array of long-latency destinations: one set port (issue),
// one clear port (writeback), three combinational read ports.
module hazard_scoreboard
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  reg_idx_t        set_idx,
    input  logic            clr_en,
    input  reg_idx_t        clr_idx,
    input  reg_idx_t        rs1_idx,
    input  reg_idx_t        rs2_idx,
    input  reg_idx_t        rd_idx,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
    output logic [NREG-1:0] busy_mask
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_next_s;

    // Next busy state: a same-cycle issue to r wins over a writeback of r.
    always_comb begin
        busy_next_s = busy_r;
        for (int r = 1; r < NREG; r++) begin
            if (set_en && (set_idx == reg_idx_t'(r))) begin
                busy_next_s[r] = 1'b1;
            end else if (clr_en && (clr_idx == reg_idx_t'(r))) begin
                busy_next_s[r] = 1'b0;
            end else begin
                busy_next_s[r] = busy_r[r];
            end
        end
        busy_next_s[0] = 1'b0;
    end

    // Busy array storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    assign rs1_busy  = busy_r[rs1_idx];
    assign rs2_busy  = busy_r[rs2_idx];
    assign rd_busy   = busy_r[rd_idx];
    assign busy_mask = busy_r;

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard detection: load-use bubble, long-op RAW/WAW stalls
// and long-op capacity throttling.
module hazard_detection_unit
    import riscv_pkg::*;
#(
    parameter int MAX_LONG = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  reg_idx_t        id_Rs1,
    input  reg_idx_t        id_Rs2,
    input  logic            id_useRs1,
    input  logic            id_useRs2,
    input  reg_idx_t        id_Rd,
    input  logic            id_regWrite,
    input  logic            id_isLoad,
    input  logic            id_isLong,
    input  logic            flush,
    input  logic            wb_valid,
    input  reg_idx_t        wb_Rd,
    output logic            stall,
    output logic            id_fire,
    output logic [NREG-1:0] busy_mask,
    output logic [3:0]      long_count
);

    localparam logic [3:0] LONG_LIMIT = 4'(MAX_LONG);

    logic       ld_pending_r;
    reg_idx_t   ld_rd_r;
    logic [3:0] long_count_r;
    logic [3:0] long_count_next_s;

    logic rs1_busy_s;
    logic rs2_busy_s;
    logic rd_busy_s;
    logic rs1_hit_s;
    logic rs2_hit_s;
    logic load_use_s;
    logic raw_long_s;
    logic waw_long_s;
    logic long_full_s;
    logic stall_s;
    logic fire_s;
    logic inc_s;
    logic dec_s;
    logic set_en_s;
    logic ld_capture_s;

    hazard_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (set_en_s),
        .set_idx   (id_Rd),
        .clr_en    (wb_valid),
        .clr_idx   (wb_Rd),
        .rs1_idx   (id_Rs1),
        .rs2_idx   (id_Rs2),
        .rd_idx    (id_Rd),
        .rs1_busy  (rs1_busy_s),
        .rs2_busy  (rs2_busy_s),
        .rd_busy   (rd_busy_s),
        .busy_mask (busy_mask)
    );

    // Stall equation. A same-cycle writeback of a busy source or
    // destination releases the stall since WB forwards into ID.
    always_comb begin
        rs1_hit_s   = id_useRs1 && is_live_reg(id_Rs1);
        rs2_hit_s   = id_useRs2 && is_live_reg(id_Rs2);
        load_use_s  = ld_pending_r &&
                      ((rs1_hit_s && (id_Rs1 == ld_rd_r)) ||
                       (rs2_hit_s && (id_Rs2 == ld_rd_r)));
        raw_long_s  = (rs1_hit_s && rs1_busy_s && !(wb_valid && (wb_Rd == id_Rs1))) ||
                      (rs2_hit_s && rs2_busy_s && !(wb_valid && (wb_Rd == id_Rs2)));
        waw_long_s  = id_regWrite && is_live_reg(id_Rd) && rd_busy_s &&
                      !(wb_valid && (wb_Rd == id_Rd));
        long_full_s = id_isLong && (long_count_r == LONG_LIMIT) && !wb_valid;
        stall_s     = id_valid && !flush &&
                      (load_use_s || raw_long_s || waw_long_s || long_full_s);
        fire_s      = id_valid && !stall_s && !flush;
        inc_s       = fire_s && id_isLong;
        dec_s       = wb_valid;
        set_en_s    = inc_s && id_regWrite && is_live_reg(id_Rd);
        ld_capture_s = fire_s && id_isLoad && id_regWrite && is_live_reg(id_Rd);
    end

    // Outstanding long-op count; simultaneous issue and writeback cancel,
    // and a stray writeback at zero is held at zero.
    always_comb begin
        case ({inc_s, dec_s})
            2'b10: begin
                long_count_next_s = long_count_r + 4'd1;
            end
            2'b01: begin
                if (long_count_r == 4'd0) begin
                    long_count_next_s = 4'd0;
                end else begin
                    long_count_next_s = long_count_r - 4'd1;
                end
            end
            default: begin
                long_count_next_s = long_count_r;
            end
        endcase
    end

    // Last-cycle load tracker; lives for exactly one cycle after the load leaves ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_pending_r <= 1'b0;
            ld_rd_r      <= REG_ZERO;
        end else begin
            ld_pending_r <= ld_capture_s;
            ld_rd_r      <= id_Rd;
        end
    end

    // Long-op counter storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_count_r <= 4'd0;
        end else begin
            long_count_r <= long_count_next_s;
        end
    end

    hazard_detection_unit_chk #(
        .MAX_LONG (MAX_LONG)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (inc_s),
        .dec        (dec_s),
        .long_count (long_count_r)
    );

    assign stall      = stall_s;
    assign id_fire    = fire_s;
    assign long_count = long_count_r;

endmodule
